// File: rtl/adc128_scan_sched.sv
// rtl/adc128_scan_sched.sv - periodic scan and software conversion scheduler for the ADC128 engine
module adc128_scan_sched #(
    parameter int DW       = 12,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cfg_en_i,
    input  logic [7:0]          cfg_ch_mask_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic                err_clr_i,
    input  logic                sw_req_i,
    input  logic [2:0]          sw_ch_i,
    output logic                sw_ack_o,
    output logic [DW-1:0]       sw_data_o,
    output logic                conv_start_o,
    output logic [2:0]          conv_ch_o,
    input  logic                conv_done_i,
    input  logic [DW-1:0]       conv_data_i,
    output logic                res_we_o,
    output logic [2:0]          res_addr_o,
    output logic [DW-1:0]       res_data_o,
    output logic                round_done_o,
    output logic                err_timeout_o,
    output logic                err_ovr_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    // The WAIT countdown starts at TIMEOUT-1 so expiry lands exactly TIMEOUT clocks after entry.
    localparam int              TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

    logic [1:0]          state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic                pend_q, pend_d;
    logic                act_q, act_d;
    logic [7:0]          mask_q, mask_d;
    logic [2:0]          ch_q, ch_d;
    logic                is_sw_q, is_sw_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                sw_ack_q, sw_ack_d;
    logic [DW-1:0]       sw_data_q, sw_data_d;
    logic                res_we_q, res_we_d;
    logic [2:0]          res_addr_q, res_addr_d;
    logic [DW-1:0]       res_data_q, res_data_d;
    logic                done_q, done_d;
    logic                err_to_q, err_to_d;
    logic                err_ovr_q, err_ovr_d;

    logic [2:0]          nxt_ch;
    logic [PERIOD_W-1:0] reload;
    logic                expire;

    // Lowest remaining channel of the current round; mask_q holds only not-yet-issued channels.
    always_comb begin
        nxt_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                nxt_ch = 3'(i);
            end
        end
    end

    // Next-state logic: period timer, round bookkeeping, conversion FSM and sticky errors.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pend_d     = pend_q;
        act_d      = act_q;
        mask_d     = mask_q;
        ch_d       = ch_q;
        is_sw_d    = is_sw_q;
        to_d       = to_q;
        sw_ack_d   = 1'b0;
        sw_data_d  = sw_data_q;
        res_we_d   = 1'b0;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;
        done_d     = 1'b0;
        err_to_d   = err_to_q & ~err_clr_i;
        err_ovr_d  = err_ovr_q & ~err_clr_i;
        expire     = 1'b0;
        reload     = (cfg_period_i == '0) ? PERIOD_W'(1) : cfg_period_i;

        case (state_q)
            S_IDLE: begin
                if (sw_req_i) begin
                    state_d = S_ISSUE;
                    ch_d    = sw_ch_i;
                    is_sw_d = 1'b1;
                end else if (!cfg_en_i) begin
                    act_d  = 1'b0;
                    pend_d = 1'b0;
                end else if (act_q) begin
                    if (mask_q != 8'd0) begin
                        state_d        = S_ISSUE;
                        ch_d           = nxt_ch;
                        is_sw_d        = 1'b0;
                        mask_d[nxt_ch] = 1'b0;
                    end else begin
                        // Round emptied by a timed-out last channel: end it quietly.
                        act_d = 1'b0;
                    end
                end else if (pend_q) begin
                    mask_d = cfg_ch_mask_i;
                    pend_d = 1'b0;
                    act_d  = (cfg_ch_mask_i != 8'd0);
                end
            end
            S_ISSUE: begin
                to_d    = TO_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done_i) begin
                    state_d = S_STORE;
                    if (is_sw_q) begin
                        sw_ack_d  = 1'b1;
                        sw_data_d = conv_data_i;
                    end else begin
                        res_we_d   = 1'b1;
                        res_addr_d = ch_q;
                        res_data_d = conv_data_i;
                        if (mask_q == 8'd0) begin
                            done_d = 1'b1;
                            act_d  = 1'b0;
                        end
                    end
                end else if (to_q == '0) begin
                    state_d  = S_IDLE;
                    err_to_d = 1'b1;
                    if (is_sw_q) begin
                        sw_ack_d  = 1'b1;
                        sw_data_d = '1;
                    end
                end else begin
                    to_d = to_q - TO_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timer runs last so an expiry re-queues a round even in the cycle a pending one starts.
        if (!cfg_en_i) begin
            timer_d = cfg_period_i;
        end else if (timer_q <= PERIOD_W'(1)) begin
            timer_d = reload;
            expire  = 1'b1;
        end else begin
            timer_d = timer_q - PERIOD_W'(1);
        end
        if (expire) begin
            pend_d = 1'b1;
            if (pend_q || act_q) begin
                err_ovr_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            timer_q    <= cfg_period_i;
            pend_q     <= 1'b0;
            act_q      <= 1'b0;
            mask_q     <= 8'd0;
            ch_q       <= 3'd0;
            is_sw_q    <= 1'b0;
            to_q       <= '0;
            sw_ack_q   <= 1'b0;
            sw_data_q  <= '0;
            res_we_q   <= 1'b0;
            res_addr_q <= 3'd0;
            res_data_q <= '0;
            done_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_ovr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            mask_q     <= mask_d;
            ch_q       <= ch_d;
            is_sw_q    <= is_sw_d;
            to_q       <= to_d;
            sw_ack_q   <= sw_ack_d;
            sw_data_q  <= sw_data_d;
            res_we_q   <= res_we_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
            done_q     <= done_d;
            err_to_q   <= err_to_d;
            err_ovr_q  <= err_ovr_d;
        end
    end

    assign conv_start_o  = (state_q == S_ISSUE);
    assign conv_ch_o     = ch_q;
    assign sw_ack_o      = sw_ack_q;
    assign sw_data_o     = sw_data_q;
    assign res_we_o      = res_we_q;
    assign res_addr_o    = res_addr_q;
    assign res_data_o    = res_data_q;
    assign round_done_o  = done_q;
    assign err_timeout_o = err_to_q;
    assign err_ovr_o     = err_ovr_q;

endmodule
